// File: rtl/keypad_code_lock.sv
// Keypad code lock: edge-detects encoder key presses, collects digits,
// checks them against a reprogrammable passcode and locks out on failures.
module keypad_code_lock #(
  parameter int NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] RESET_CODE = 16'h1234,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] bcd_in,
  input  logic       mode,
  input  logic       clear,
  output logic       unlocked,
  output logic       alarm,
  output logic       err_pulse,
  output logic       prog_done,
  output logic [2:0] digit_count,
  output logic [2:0] fail_count
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0]    ND   = 3'(NUM_DIGITS);
  localparam logic [2:0]    MF   = 3'(MAX_FAILS);
  localparam logic [CW-1:0] LOAD = CW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_OPEN,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic          prev_q;
  logic [W-1:0]  entry_q, entry_d;
  logic [W-1:0]  code_q, code_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic [2:0]    fcnt_q, fcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          err_q, err_d;
  logic          prog_q, prog_d;

  logic          key_ok;
  logic [W-1:0]  shifted;
  logic [2:0]    dcnt_inc;
  logic [2:0]    fcnt_inc;

  assign key_ok   = bcd_in[4] & ~prev_q & (bcd_in[3:0] <= 4'd9);
  assign dcnt_inc = dcnt_q + 3'd1;
  assign fcnt_inc = fcnt_q + 3'd1;

  always_comb begin
    shifted = entry_q << 4;
    shifted[3:0] = bcd_in[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOCKED;
      prev_q  <= 1'b1;
      entry_q <= '0;
      code_q  <= RESET_CODE;
      dcnt_q  <= '0;
      fcnt_q  <= '0;
      lcnt_q  <= '0;
      err_q   <= 1'b0;
      prog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= bcd_in[4];
      entry_q <= entry_d;
      code_q  <= code_d;
      dcnt_q  <= dcnt_d;
      fcnt_q  <= fcnt_d;
      lcnt_q  <= lcnt_d;
      err_q   <= err_d;
      prog_q  <= prog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    code_d  = code_q;
    dcnt_d  = dcnt_q;
    fcnt_d  = fcnt_q;
    lcnt_d  = lcnt_q;
    err_d   = 1'b0;
    prog_d  = 1'b0;
    unique case (state_q)
      S_LOCKED: begin
        if (clear) begin
          entry_d = '0;
          dcnt_d  = '0;
        end else if (key_ok) begin
          entry_d = shifted;
          dcnt_d  = dcnt_inc;
          if (dcnt_inc == ND) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        entry_d = '0;
        dcnt_d  = '0;
        if (entry_q == code_q) begin
          state_d = S_OPEN;
          fcnt_d  = '0;
        end else begin
          err_d  = 1'b1;
          fcnt_d = fcnt_inc;
          if (fcnt_inc == MF) begin
            state_d = S_LOCKOUT;
            lcnt_d  = LOAD;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end
      S_OPEN: begin
        if (clear) begin
          state_d = S_LOCKED;
          dcnt_d  = '0;
        end else if (mode) begin
          state_d = S_PROGRAM;
          entry_d = '0;
          dcnt_d  = '0;
        end
      end
      S_PROGRAM: begin
        if (clear || !mode) begin
          state_d = S_OPEN;
          entry_d = '0;
          dcnt_d  = '0;
        end else if (key_ok) begin
          if (dcnt_inc == ND) begin
            state_d = S_OPEN;
            code_d  = shifted;
            prog_d  = 1'b1;
            entry_d = '0;
            dcnt_d  = '0;
          end else begin
            entry_d = shifted;
            dcnt_d  = dcnt_inc;
          end
        end
      end
      S_LOCKOUT: begin
        if (lcnt_q == '0) begin
          state_d = S_LOCKED;
          fcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q - CW'(1);
        end
      end
      default: state_d = S_LOCKED;
    endcase
  end

  assign unlocked    = (state_q == S_OPEN) || (state_q == S_PROGRAM);
  assign alarm       = (state_q == S_LOCKOUT);
  assign err_pulse   = err_q;
  assign prog_done   = prog_q;
  assign digit_count = dcnt_q;
  assign fail_count  = fcnt_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: per-cycle vector table fed through a
// scoreboard queue, plus directed reset / abort / held-key sequences.
module tb_keypad_code_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] bcd_in;
  logic       mode;
  logic       clear;
  logic       unlocked;
  logic       alarm;
  logic       err_pulse;
  logic       prog_done;
  logic [2:0] digit_count;
  logic [2:0] fail_count;

  always #5 clk = ~clk;

  keypad_code_lock dut (
    .clk(clk),
    .rst(rst),
    .bcd_in(bcd_in),
    .mode(mode),
    .clear(clear),
    .unlocked(unlocked),
    .alarm(alarm),
    .err_pulse(err_pulse),
    .prog_done(prog_done),
    .digit_count(digit_count),
    .fail_count(fail_count)
  );

  // expected word: {unlocked, alarm, err, prog, digit_count, fail_count}
  typedef struct {
    logic [4:0] bcd;
    logic       mode;
    logic       clr;
    int         n;
    logic [9:0] exp;
    string      tag;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb_q[$];
  string      tag_q[$];
  int         tests = 0;
  int         fails = 0;

  function automatic logic [9:0] pk(logic u, logic a, logic e, logic p,
                                    logic [2:0] d, logic [2:0] f);
    return {u, a, e, p, d, f};
  endfunction

  function automatic logic [9:0] outs();
    return {unlocked, alarm, err_pulse, prog_done, digit_count, fail_count};
  endfunction

  function automatic void add(string t, logic [4:0] b, logic m, logic c,
                              int n, logic [9:0] e);
    tbl.push_back('{bcd: b, mode: m, clr: c, n: n, exp: e, tag: t});
  endfunction

  function automatic void dig(logic [3:0] d, logic m, logic [2:0] dc,
                              logic u, logic [2:0] fc);
    add("press", {1'b1, d}, m, 1'b0, 1, pk(u, 0, 0, 0, dc, fc));
    add("hold", {1'b1, d}, m, 1'b0, 2, pk(u, 0, 0, 0, dc, fc));
    add("gap", 5'd0, m, 1'b0, 2, pk(u, 0, 0, 0, dc, fc));
  endfunction

  function automatic void fin_ok(logic [3:0] d, logic [2:0] fc);
    add("check_ok", {1'b1, d}, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 3'd4, fc));
    add("open", {1'b1, d}, 1'b0, 1'b0, 2, pk(1, 0, 0, 0, 0, 0));
    add("open_gap", 5'd0, 1'b0, 1'b0, 2, pk(1, 0, 0, 0, 0, 0));
  endfunction

  function automatic void fin_bad(logic [3:0] d, logic [2:0] fc, logic lk);
    logic [2:0] fn;
    fn = fc + 3'd1;
    add("check_bad", {1'b1, d}, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 3'd4, fc));
    add("err", {1'b1, d}, 1'b0, 1'b0, 1, pk(0, lk, 1, 0, 0, fn));
    add("err_hold", {1'b1, d}, 1'b0, 1'b0, 1, pk(0, lk, 0, 0, 0, fn));
    add("err_gap", 5'd0, 1'b0, 1'b0, 2, pk(0, lk, 0, 0, 0, fn));
  endfunction

  function automatic void relock();
    add("relock", 5'd0, 1'b0, 1'b1, 1, pk(0, 0, 0, 0, 0, 0));
    add("idle", 5'd0, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0, 0));
  endfunction

  function automatic void chk(string t, logic [9:0] act, logic [9:0] e);
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", t, act, e);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      chk(tag_q.pop_front(), outs(), sb_q.pop_front());
    end
  end

  task automatic drive(logic [4:0] b, logic m, logic c);
    @(negedge clk);
    bcd_in = b;
    mode   = m;
    clear  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(logic [3:0] d, logic m);
    drive({1'b1, d}, m, 1'b0);
    drive(5'd0, m, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bcd_in = '0;
    mode = 1'b0;
    clear = 1'b0;
    drive(5'd0, 1'b0, 1'b0);
    drive(5'd0, 1'b0, 1'b0);
    chk("reset_state", outs(), 10'd0);
    rst = 1'b0;
    drive(5'd0, 1'b0, 1'b0);

    // correct code
    dig(4'd1, 0, 3'd1, 0, 0);
    dig(4'd2, 0, 3'd2, 0, 0);
    dig(4'd3, 0, 3'd3, 0, 0);
    fin_ok(4'd4, 0);
    relock();
    // three failures into lockout
    for (int k = 0; k < 3; k++) begin
      dig(4'd9, 0, 3'd1, 0, 3'(k));
      dig(4'd9, 0, 3'd2, 0, 3'(k));
      dig(4'd9, 0, 3'd3, 0, 3'(k));
      fin_bad(4'd9, 3'(k), k == 2);
    end
    add("lk_press", 5'b10101, 1'b0, 1'b0, 3, pk(0, 1, 0, 0, 0, 3));
    add("lk_clear", 5'd0, 1'b0, 1'b1, 4, pk(0, 1, 0, 0, 0, 3));
    add("lk_wait", 5'd0, 1'b0, 1'b0, 5, pk(0, 1, 0, 0, 0, 3));
    add("lk_done", 5'd0, 1'b0, 1'b0, 2, pk(0, 0, 0, 0, 0, 0));
    // reprogram to 5678
    dig(4'd1, 0, 3'd1, 0, 0);
    dig(4'd2, 0, 3'd2, 0, 0);
    dig(4'd3, 0, 3'd3, 0, 0);
    fin_ok(4'd4, 0);
    add("pmode", 5'd0, 1'b1, 1'b0, 1, pk(1, 0, 0, 0, 0, 0));
    dig(4'd5, 1, 3'd1, 1, 0);
    dig(4'd6, 1, 3'd2, 1, 0);
    dig(4'd7, 1, 3'd3, 1, 0);
    add("pdone", 5'b11000, 1'b1, 1'b0, 1, pk(1, 0, 0, 1, 0, 0));
    add("phold", 5'b11000, 1'b0, 1'b0, 2, pk(1, 0, 0, 0, 0, 0));
    add("pgap", 5'd0, 1'b0, 1'b0, 1, pk(1, 0, 0, 0, 0, 0));
    relock();
    dig(4'd1, 0, 3'd1, 0, 0);
    dig(4'd2, 0, 3'd2, 0, 0);
    dig(4'd3, 0, 3'd3, 0, 0);
    fin_bad(4'd4, 0, 0);
    dig(4'd5, 0, 3'd1, 0, 1);
    dig(4'd6, 0, 3'd2, 0, 1);
    dig(4'd7, 0, 3'd3, 0, 1);
    fin_ok(4'd8, 1);
    relock();
    // boundaries
    add("hold10", 5'b10001, 1'b0, 1'b0, 10, pk(0, 0, 0, 0, 1, 0));
    add("gap", 5'd0, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 1, 0));
    add("press_clr", 5'b10010, 1'b0, 1'b1, 1, pk(0, 0, 0, 0, 0, 0));
    add("press_clr_h", 5'b10010, 1'b0, 1'b0, 2, pk(0, 0, 0, 0, 0, 0));
    add("gap", 5'd0, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0, 0));
    add("key_f", 5'b11111, 1'b0, 1'b0, 2, pk(0, 0, 0, 0, 0, 0));
    add("gap", 5'd0, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0, 0));
    add("key_a", 5'b11010, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0, 0));
    add("gap", 5'd0, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        @(negedge clk);
        bcd_in = tbl[i].bcd;
        mode   = tbl[i].mode;
        clear  = tbl[i].clr;
        sb_q.push_back(tbl[i].exp);
        tag_q.push_back(tbl[i].tag);
      end
    end
    @(posedge clk);
    #2;
    chk("sb_drained", 10'(sb_q.size()), 10'd0);

    // reset during a program entry restores the reset code
    press_key(4'd5, 1'b0);
    press_key(4'd6, 1'b0);
    press_key(4'd7, 1'b0);
    press_key(4'd8, 1'b0);
    chk("open_5678", outs(), pk(1, 0, 0, 0, 0, 0));
    drive(5'd0, 1'b1, 1'b0);
    press_key(4'd1, 1'b1);
    press_key(4'd2, 1'b1);
    chk("prog_two", outs(), pk(1, 0, 0, 0, 2, 0));
    rst = 1'b1;
    drive(5'd0, 1'b1, 1'b0);
    chk("mid_reset", outs(), 10'd0);
    rst = 1'b0;
    drive(5'd0, 1'b0, 1'b0);
    press_key(4'd1, 1'b0);
    press_key(4'd2, 1'b0);
    press_key(4'd3, 1'b0);
    press_key(4'd4, 1'b0);
    chk("revert_1234", outs(), pk(1, 0, 0, 0, 0, 0));

    // abort a program entry
    drive(5'd0, 1'b1, 1'b0);
    press_key(4'd5, 1'b1);
    press_key(4'd6, 1'b1);
    chk("abort_two", outs(), pk(1, 0, 0, 0, 2, 0));
    drive(5'd0, 1'b0, 1'b0);
    chk("abort_open", outs(), pk(1, 0, 0, 0, 0, 0));
    drive(5'd0, 1'b0, 1'b1);
    chk("abort_lock", outs(), pk(0, 0, 0, 0, 0, 0));
    press_key(4'd5, 1'b0);
    press_key(4'd6, 1'b0);
    press_key(4'd7, 1'b0);
    press_key(4'd8, 1'b0);
    chk("abort_5678", outs(), pk(0, 0, 1, 0, 0, 1));
    press_key(4'd1, 1'b0);
    press_key(4'd2, 1'b0);
    press_key(4'd3, 1'b0);
    press_key(4'd4, 1'b0);
    chk("abort_1234", outs(), pk(1, 0, 0, 0, 0, 0));

    // key held across reset release
    rst = 1'b1;
    drive(5'b10011, 1'b0, 1'b0);
    drive(5'b10011, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(5'b10011, 1'b0, 1'b0);
    chk("held_reset", outs(), pk(0, 0, 0, 0, 0, 0));
    drive(5'd0, 1'b0, 1'b0);
    press_key(4'd3, 1'b0);
    chk("after_held", outs(), pk(0, 0, 0, 0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_code_lock.md
# keypad_code_lock

- Stage directly downstream of the keypad encoder.
- Consumes the 5-bit {valid, BCD} code, edge-detects key presses and collects digits into an entry buffer.
- Compares a complete entry against a stored passcode; drives unlock, error and alarm outputs.
- Supports reprogramming the passcode while unlocked, and a timed lockout after repeated failures.

## Interface
Parameters:
- NUM_DIGITS, 4, digits per code; legal range 1..7.
- RESET_CODE, 16'h1234, passcode loaded at reset; width 4*NUM_DIGITS; first-entered digit in the most significant nibble.
- MAX_FAILS, 3, consecutive mismatches that trigger lockout; legal range 1..7.
- LOCKOUT_CYCLES, 16, lockout duration in clk cycles; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- bcd_in  in  5  bit4 = key valid, bits3:0 = BCD digit (encoder output).
- mode  in  1  0 = check, 1 = program request (level).
- clear  in  1  level; cancel/relock (see Operation).
- unlocked  out  1  high while in OPEN or PROGRAM.
- alarm  out  1  high while in LOCKOUT.
- err_pulse  out  1  one-cycle pulse on a mismatch.
- prog_done  out  1  one-cycle pulse when a new code is stored.
- digit_count  out  3  digits collected in the current entry.
- fail_count  out  3  consecutive mismatches since the last success or lockout expiry.

## Operation
Reset values:
- State LOCKED; entry buffer 0; stored code RESET_CODE; digit_count 0; fail_count 0.
- unlocked, alarm, err_pulse and prog_done all 0.
- prev_valid = 1, so a key still held through reset is not captured.

Press detection:
- A press is bcd_in[4]=1 while prev_valid=0; prev_valid <= bcd_in[4] every cycle.
- Digit = bcd_in[3:0] in the press cycle.
- A press with digit > 9 is ignored.
- Holding a key produces exactly one press.

State machine (LOCKED, CHECK, OPEN, PROGRAM, LOCKOUT):
- **LOCKED:**
  - Each press shifts the digit into the buffer LSB nibble and increments digit_count.
  - The press that makes digit_count == NUM_DIGITS moves to CHECK.
  - clear empties the buffer and sets digit_count = 0.
- **CHECK (exactly 1 cycle):**
  - Presses are ignored.
  - Buffer == stored → OPEN, fail_count = 0.
  - Otherwise err_pulse = 1 and fail_count++. If the new fail_count == MAX_FAILS → LOCKOUT, else → LOCKED.
  - digit_count = 0 on exit in every case.
- **OPEN:**
  - Presses are ignored.
  - clear=1 → LOCKED. clear has priority over mode.
  - mode=1 → PROGRAM with digit_count = 0.
- **PROGRAM:**
  - Presses collect as in LOCKED.
  - The press completing NUM_DIGITS copies the full buffer (including that digit) into the stored code, pulses prog_done, and returns to OPEN.
  - mode=0 or clear=1 before completion aborts to OPEN with the stored code unchanged and digit_count = 0.
- **LOCKOUT:**
  - All presses and clear are ignored.
  - Counter is loaded with LOCKOUT_CYCLES-1 on entry and decrements each cycle.
  - At 0 → LOCKED with fail_count = 0.

Precedence and width rules:
- Press and clear in the same cycle: clear wins; the digit is discarded.
- rst mid-operation (any state): returns to the reset values, including the stored code reverting to RESET_CODE.
- digit_count never exceeds NUM_DIGITS.
- fail_count never exceeds MAX_FAILS.

## Timing
- Press sampled at edge N: digit_count updates after edge N.
- Final digit at edge N:
  - CHECK is active in the N..N+1 cycle.
  - unlocked, err_pulse, alarm or LOCKED take effect after edge N+1.
  - Press-to-result latency is 2 edges.
- err_pulse and prog_done are high for exactly one cycle.
- prog_done rises after the same edge that captures the final digit.
- alarm stays high for exactly LOCKOUT_CYCLES cycles. unlocked stays low throughout LOCKOUT.
- Minimum press spacing is 2 cycles: valid must go low for at least 1 cycle between presses.

## Test plan
- **Correct code:** reset, press 1,2,3,4 (each valid for 3 cycles, 2-cycle gap) → digit_count 1..4; unlocked=1 two edges after the 4th press; fail_count=0.
- **Lockout:** enter 9,9,9,9 three times → err_pulse once per entry; fail_count 1, 2, 3. After the third entry, alarm=1 for exactly 16 cycles. Presses during alarm do not change digit_count. Then LOCKED with fail_count=0.
- **Reprogram:**
  - Unlock with 1234; set mode=1 and press 5,6,7,8 → prog_done pulse.
  - Set mode=0 and clear=1 → locked.
  - 1234 → err_pulse; 5678 → unlocked.
- **Abort:** unlocked, mode=1, press 5,6, drop mode → OPEN, digit_count 0; stored code is still 1234.
- **Boundaries:**
  - Key held for 10 cycles → single digit.
  - Press coincident with clear → digit_count 0.
  - bcd_in = 5'b11111 → ignored.
  - bcd_in[4] held high across reset release → no capture.
- **Reset mid-operation:** rst after 2 digits of a program entry → all outputs 0; stored code reverts to 1234.
